// File: rtl/l2_cache.sv
// ---------------------------------------------------------------------------
// l2_cache
//   Set-associative, write-through, write-allocate L2 cache moving whole
//   blocks between the L1 block interface and main memory.
//   Read hits answer one cycle after the request edge. Read misses fetch the
//   block from memory and stall until mem_ready. Writes (hit or miss) update
//   the line and are posted to memory as a one-cycle write pulse.
//
// Ports
//   clk                rising-edge clock
//   rst_n              asynchronous reset, ACTIVE-HIGH despite the name
//   l1_cache_addr      block address of the L1 request
//   l1_cache_data_in   write block from L1 (word i at [i*DATA_WIDTH +: DATA_WIDTH])
//   l1_block_data_out  read block to L1, holds between pulses
//   l1_block_valid     pulse: l1_block_data_out valid (reads only)
//   l1_cache_read      read request
//   l1_cache_write     write request (wins over a simultaneous read)
//   l1_cache_ready     pulse: request complete
//   l1_cache_hit       qualifies l1_cache_ready (1 = hit)
//   mem_data_block     fill block from memory
//   mem_ready          fill block valid
//   mem_addr           memory block address
//   mem_data_out       write-through block
//   mem_read           block read request, held until mem_ready
//   mem_write          one-cycle posted block write
// ---------------------------------------------------------------------------
module l2_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            l1_cache_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_cache_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out,
  output logic                             l1_block_valid,
  input  logic                             l1_cache_read,
  input  logic                             l1_cache_write,
  output logic                             l1_cache_ready,
  output logic                             l1_cache_hit,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
  input  logic                             mem_ready,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  output logic                             mem_read,
  output logic                             mem_write
);

  localparam int NUM_SETS   = CACHE_SIZE / NUM_WAYS;
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
  localparam int WAY_BITS   = $clog2(NUM_WAYS);
  localparam int BLOCK_BITS = BLOCK_SIZE * DATA_WIDTH;
  localparam logic [WAY_BITS-1:0] AGE_MAX = WAY_BITS'(NUM_WAYS - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t state;

  // Line storage. Age 0 is most recently used; larger ages are older.
  logic [BLOCK_BITS-1:0] data_mem  [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]   tag_mem   [NUM_SETS][NUM_WAYS];
  logic                  valid_mem [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]   age_mem   [NUM_SETS][NUM_WAYS];

  // Outstanding miss bookkeeping
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [WAY_BITS-1:0]   miss_way;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic                  found_invalid;
  logic [WAY_BITS-1:0]   victim_way;
  logic [WAY_BITS-1:0]   best_age;

  logic                  do_write;
  logic                  do_read;
  logic                  do_fill;
  logic                  touch_en;
  logic                  arr_we;
  logic [INDEX_BITS-1:0] arr_set;
  logic [WAY_BITS-1:0]   arr_way;
  logic [TAG_BITS-1:0]   arr_tag;
  logic [BLOCK_BITS-1:0] arr_data;
  logic [WAY_BITS-1:0]   touch_old;

  assign req_index = l1_cache_addr[INDEX_BITS-1:0];
  assign req_tag   = l1_cache_addr[ADDR_WIDTH-1:INDEX_BITS];

  // Tag lookup and victim choice for the set addressed by the L1 request.
  // The victim is the lowest-numbered invalid way; once the set is full it is
  // the oldest way (ties, which should not occur, go to the lower index).
  always_comb begin
    hit           = 1'b0;
    hit_way       = '0;
    found_invalid = 1'b0;
    victim_way    = '0;
    best_age      = age_mem[req_index][0];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_mem[req_index][w] && tag_mem[req_index][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_invalid && !valid_mem[req_index][w]) begin
        found_invalid = 1'b1;
        victim_way    = WAY_BITS'(w);
      end
    end
    if (!found_invalid) begin
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (age_mem[req_index][w] > best_age) begin
          best_age   = age_mem[req_index][w];
          victim_way = WAY_BITS'(w);
        end
      end
    end
  end

  // Decide which line (if any) is written or touched this cycle. A fill uses
  // the way latched at miss time; an L1 write uses the hit way or the victim.
  always_comb begin
    do_write = (state == IDLE) && l1_cache_write;
    do_read  = (state == IDLE) && !l1_cache_write && l1_cache_read;
    do_fill  = (state == MEM_WAIT) && mem_ready;
    arr_we   = do_write || do_fill;
    touch_en = arr_we || (do_read && hit);
    if (do_fill) begin
      arr_set  = miss_addr[INDEX_BITS-1:0];
      arr_way  = miss_way;
      arr_tag  = miss_addr[ADDR_WIDTH-1:INDEX_BITS];
      arr_data = mem_data_block;
    end else begin
      arr_set  = req_index;
      arr_way  = hit ? hit_way : victim_way;
      arr_tag  = req_tag;
      arr_data = l1_cache_data_in;
    end
    // A freshly allocated way counts as the oldest before it is promoted, so
    // every valid way in the set ages by one and ages stay distinct.
    touch_old = valid_mem[arr_set][arr_way] ? age_mem[arr_set][arr_way] : AGE_MAX;
  end

  // Block data array. It carries no reset because validity is tracked
  // separately and stale data is never returned.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_mem[arr_set][arr_way] <= arr_data;
    end
  end

  // Main controller: tag/valid/age state, the IDLE/MEM_WAIT sequencing and
  // all registered outputs. Pulses default to 0 every cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state             <= IDLE;
      miss_addr         <= '0;
      miss_way          <= '0;
      l1_block_data_out <= '0;
      l1_block_valid    <= 1'b0;
      l1_cache_ready    <= 1'b0;
      l1_cache_hit      <= 1'b0;
      mem_addr          <= '0;
      mem_data_out      <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_mem[s][w] <= 1'b0;
          tag_mem[s][w]   <= '0;
          age_mem[s][w]   <= '0;
        end
      end
    end else begin
      l1_block_valid <= 1'b0;
      l1_cache_ready <= 1'b0;
      l1_cache_hit   <= 1'b0;
      mem_write      <= 1'b0;

      if (touch_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (w != int'(arr_way) && age_mem[arr_set][w] < touch_old) begin
            age_mem[arr_set][w] <= age_mem[arr_set][w] + 1'b1;
          end
        end
        age_mem[arr_set][arr_way] <= '0;
      end

      if (arr_we) begin
        valid_mem[arr_set][arr_way] <= 1'b1;
        tag_mem[arr_set][arr_way]   <= arr_tag;
      end

      case (state)
        IDLE: begin
          if (do_write) begin
            mem_write      <= 1'b1;
            mem_addr       <= l1_cache_addr;
            mem_data_out   <= l1_cache_data_in;
            l1_cache_ready <= 1'b1;
            l1_cache_hit   <= hit;
          end else if (do_read) begin
            if (hit) begin
              l1_block_data_out <= data_mem[req_index][hit_way];
              l1_block_valid    <= 1'b1;
              l1_cache_ready    <= 1'b1;
              l1_cache_hit      <= 1'b1;
            end else begin
              miss_addr <= l1_cache_addr;
              miss_way  <= victim_way;
              mem_read  <= 1'b1;
              mem_addr  <= l1_cache_addr;
              state     <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            l1_block_data_out <= mem_data_block;
            l1_block_valid    <= 1'b1;
            l1_cache_ready    <= 1'b1;
            l1_cache_hit      <= 1'b0;
            mem_read          <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// ---------------------------------------------------------------------------
// tb_l2_cache
//   Directed scoreboard bench for l2_cache. Each request pushes its expected
//   L1 response (and, for writes, the expected memory write) into queues; two
//   monitor processes pop and compare whenever the DUT pulses l1_cache_ready
//   or mem_write.
// ---------------------------------------------------------------------------
module tb_l2_cache;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 32;
  localparam int BW = BS * DW;

  typedef logic [BW-1:0] blk_t;

  typedef struct {
    logic is_read;
    logic hit;
    blk_t data;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    blk_t          data;
  } mwr_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] l1_cache_addr;
  blk_t          l1_cache_data_in;
  blk_t          l1_block_data_out;
  logic          l1_block_valid;
  logic          l1_cache_read;
  logic          l1_cache_write;
  logic          l1_cache_ready;
  logic          l1_cache_hit;
  blk_t          mem_data_block;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  blk_t          mem_data_out;
  logic          mem_read;
  logic          mem_write;

  int total;
  int bad;

  resp_t resp_q[$];
  mwr_t  mwr_q[$];

  l2_cache dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .l1_cache_addr     (l1_cache_addr),
    .l1_cache_data_in  (l1_cache_data_in),
    .l1_block_data_out (l1_block_data_out),
    .l1_block_valid    (l1_block_valid),
    .l1_cache_read     (l1_cache_read),
    .l1_cache_write    (l1_cache_write),
    .l1_cache_ready    (l1_cache_ready),
    .l1_cache_hit      (l1_cache_hit),
    .mem_data_block    (mem_data_block),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_data_out      (mem_data_out),
    .mem_read          (mem_read),
    .mem_write         (mem_write)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block whose word i is base ^ i
  function automatic blk_t xor_block(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = base ^ 32'(i);
    return b;
  endfunction

  // Memory contents the bench returns for a fill of block address a
  function automatic blk_t fill_block(input logic [AW-1:0] a);
    blk_t b;
    if (a == 11'h00A) return xor_block(32'hDEADBEEF);
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = {5'b0, a, 16'(i)};
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkBlock(input string name, input blk_t actual, input blk_t expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got word0=%h word31=%h expected word0=%h word31=%h",
               name, actual[0 +: DW], actual[31*DW +: DW],
               expected[0 +: DW], expected[31*DW +: DW]);
    end
  endtask

  // L1 response monitor: compares every ready pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst_n && l1_cache_ready) begin
      if (resp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ready: got ready=1 expected no response");
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        checkOutput("resp_hit", 64'(l1_cache_hit), 64'(e.hit));
        checkOutput("resp_block_valid", 64'(l1_block_valid), 64'(e.is_read));
        if (e.is_read) checkBlock("resp_data", l1_block_data_out, e.data);
      end
    end
  end

  // Memory write monitor: every posted write must match the scoreboard
  always @(negedge clk) begin
    if (!rst_n && mem_write) begin
      if (mwr_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_mem_write: got mem_write=1 addr=%h expected none", mem_addr);
      end else begin
        mwr_t m;
        m = mwr_q.pop_front();
        checkOutput("mem_write_addr", 64'(mem_addr), 64'(m.addr));
        checkBlock("mem_write_data", mem_data_out, m.data);
      end
    end
  end

  // Issue one L1 request. For reads, data is the expected returned block and,
  // on a miss, also the block the bench returns from memory.
  task automatic applyStimulus(input logic is_write, input logic also_read,
                               input logic [AW-1:0] addr, input blk_t data,
                               input logic exp_hit);
    resp_t r;
    mwr_t  m;
    int    n;
    @(negedge clk);
    r.is_read = !is_write;
    r.hit     = exp_hit;
    r.data    = data;
    resp_q.push_back(r);
    if (is_write) begin
      m.addr = addr;
      m.data = data;
      mwr_q.push_back(m);
    end
    l1_cache_addr    = addr;
    l1_cache_data_in = is_write ? data : '0;
    l1_cache_write   = is_write;
    l1_cache_read    = !is_write || also_read;
    @(negedge clk);
    l1_cache_write = 1'b0;
    l1_cache_read  = 1'b0;
    if (!is_write && !exp_hit) begin
      checkOutput("miss_mem_read", 64'(mem_read), 64'd1);
      checkOutput("miss_mem_addr", 64'(mem_addr), 64'(addr));
      // A request during the fill must be ignored
      l1_cache_write   = 1'b1;
      l1_cache_data_in = xor_block(32'h0BAD0BAD);
      @(negedge clk);
      l1_cache_write = 1'b0;
      checkOutput("miss_mem_read_held", 64'(mem_read), 64'd1);
      mem_data_block = data;
      mem_ready      = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("fill_mem_read_drop", 64'(mem_read), 64'd0);
    end else if (!is_write) begin
      checkOutput("hit_no_mem_read", 64'(mem_read), 64'd0);
    end
    n = 0;
    while ((resp_q.size() != 0 || mwr_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("[TB] FAIL response_timeout: got %0d pending expected 0 (addr %h)",
               resp_q.size() + mwr_q.size(), addr);
      resp_q.delete();
      mwr_q.delete();
    end
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total            = 0;
    bad              = 0;
    rst_n            = 1'b1;
    l1_cache_addr    = '0;
    l1_cache_data_in = '0;
    l1_cache_read    = 1'b0;
    l1_cache_write   = 1'b0;
    mem_data_block   = '0;
    mem_ready        = 1'b0;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_read", 64'(mem_read), 64'd0);
    checkOutput("rst_mem_write", 64'(mem_write), 64'd0);
    checkOutput("rst_ready", 64'(l1_cache_ready), 64'd0);
    checkOutput("rst_valid", 64'(l1_block_valid), 64'd0);
    checkOutput("rst_hit", 64'(l1_cache_hit), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_block_out_any", 64'(|l1_block_data_out), 64'd0);
    checkOutput("rst_mem_data_any", 64'(|mem_data_out), 64'd0);
    rst_n = 1'b0;

    $display("[TB] read miss then hit on 0x00A");
    applyStimulus(1'b0, 1'b0, 11'h00A, fill_block(11'h00A), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h00A, xor_block(32'hDEADBEEF), 1'b1);
    checkOutput("hit_word0", 64'(l1_block_data_out[0 +: DW]), 64'h00000000DEADBEEF);
    checkOutput("hit_word31", 64'(l1_block_data_out[31*DW +: DW]), 64'h00000000DEADBEF0);

    $display("[TB] write miss, write hit (with simultaneous read), read hit on 0x014");
    applyStimulus(1'b1, 1'b0, 11'h014, xor_block(32'hA5A5A5A5), 1'b0);
    applyStimulus(1'b1, 1'b1, 11'h014, xor_block(32'h5A5A5A5A), 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h014, xor_block(32'h5A5A5A5A), 1'b1);

    $display("[TB] fill set 2 and check LRU eviction");
    applyStimulus(1'b0, 1'b0, 11'h002, fill_block(11'h002), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h00A, fill_block(11'h00A), 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h012, fill_block(11'h012), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h01A, fill_block(11'h01A), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h002, fill_block(11'h002), 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h022, fill_block(11'h022), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h00A, fill_block(11'h00A), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h01A, fill_block(11'h01A), 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h022, fill_block(11'h022), 1'b1);

    $display("[TB] reset during a miss");
    @(negedge clk);
    l1_cache_addr = 11'h032;
    l1_cache_read = 1'b1;
    @(negedge clk);
    l1_cache_read = 1'b0;
    checkOutput("abort_mem_read_before", 64'(mem_read), 64'd1);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("abort_mem_read_async", 64'(mem_read), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 11'h00A, fill_block(11'h00A), 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h014, fill_block(11'h014), 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
